// File: rtl/ox_grid_collector.sv
// ox_grid_collector: toggles 4x4 drawing-grid cells from one-hot key events and hands the frozen grid to the O/X classifier.
// Latency: every output is registered. Edits are visible 1 cycle after the event, and cls_req rises 1 cycle after the submit.
// Backpressure: while cls_req is high, all edits, clears and submits are dropped until cls_ack arrives.
module ox_grid_collector #(
  parameter int unsigned AUTO_SUBMIT_CYCLES = 0,
  parameter int unsigned CNT_W              = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_value,
  input  logic        key_valid,
  input  logic        clear,
  input  logic        submit,
  input  logic        cls_ack,
  input  logic [1:0]  cls_result,
  output logic [15:0] grid,
  output logic [4:0]  cell_count,
  output logic [3:0]  last_idx,
  output logic        last_idx_valid,
  output logic        cls_req,
  output logic [1:0]  result,
  output logic        result_valid,
  output logic        err_multi
);

  typedef enum logic {ST_EDIT, ST_REQ} state_t;

  // Saturation ceiling and fire point of the idle counter. The fire point wraps when
  // auto-submit is disabled, but it is never used in that case.
  localparam logic [CNT_W-1:0] LP_AUTO = CNT_W'(AUTO_SUBMIT_CYCLES);
  localparam logic [CNT_W-1:0] LP_FIRE = LP_AUTO - CNT_W'(1);
  localparam bit               LP_AUTO_EN = (AUTO_SUBMIT_CYCLES != 0);

  state_t           r_state;
  logic             r_key_prev;
  logic [CNT_W-1:0] r_idle_cnt;

  logic       w_key_evt;
  logic       w_onehot;
  logic [3:0] w_idx;
  logic       w_cell_set;
  logic       w_has_cells;
  logic       w_idle_inc;
  logic       w_auto_fire;

  assign w_key_evt   = key_valid & ~r_key_prev;
  assign w_onehot    = (key_value != 16'd0) && ((key_value & (key_value - 16'd1)) == 16'd0);
  assign w_cell_set  = |(grid & key_value);
  assign w_has_cells = (cell_count != 5'd0);
  assign w_idle_inc  = w_has_cells && (r_idle_cnt < LP_AUTO);
  assign w_auto_fire = LP_AUTO_EN && w_has_cells && (r_idle_cnt == LP_FIRE);

  // Encode the pressed key bit into a cell index. The result is only used when exactly one bit is set.
  always_comb begin
    w_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (key_value[i]) w_idx = 4'(i);
    end
  end

  // Main control: edit/submit/auto-submit in EDIT, then wait for the classifier verdict in REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_EDIT;
      r_key_prev     <= 1'b0;
      r_idle_cnt     <= '0;
      grid           <= 16'd0;
      cell_count     <= 5'd0;
      last_idx       <= 4'd0;
      last_idx_valid <= 1'b0;
      cls_req        <= 1'b0;
      result         <= 2'b00;
      result_valid   <= 1'b0;
      err_multi      <= 1'b0;
    end else begin
      // The edge register keeps tracking in REQ, so a key held across the return to EDIT is not replayed.
      r_key_prev <= key_valid;
      err_multi  <= 1'b0;
      case (r_state)
        ST_EDIT: begin
          if (clear) begin
            grid           <= 16'd0;
            cell_count     <= 5'd0;
            last_idx_valid <= 1'b0;
            r_idle_cnt     <= '0;
          end else if (submit && w_has_cells) begin
            r_state <= ST_REQ;
            cls_req <= 1'b1;
          end else if (w_key_evt) begin
            if (w_onehot) begin
              grid           <= grid ^ key_value;
              cell_count     <= w_cell_set ? (cell_count - 5'd1) : (cell_count + 5'd1);
              last_idx       <= w_idx;
              last_idx_valid <= 1'b1;
              r_idle_cnt     <= '0;
            end else begin
              // A rejected event is not an edit, so the idle count keeps running.
              err_multi <= 1'b1;
              if (w_idle_inc) r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end
          end else if (w_auto_fire) begin
            r_state <= ST_REQ;
            cls_req <= 1'b1;
          end else if (w_idle_inc) begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
          end
        end
        ST_REQ: begin
          if (cls_ack) begin
            result         <= cls_result;
            result_valid   <= 1'b1;
            grid           <= 16'd0;
            cell_count     <= 5'd0;
            last_idx_valid <= 1'b0;
            r_idle_cnt     <= '0;
            cls_req        <= 1'b0;
            r_state        <= ST_EDIT;
          end
        end
        default: r_state <= ST_EDIT;
      endcase
    end
  end

endmodule
